// File: rtl/cpu_dbg_pkg.sv
// Shared debug definitions: dump controller states, dump cause codes and the
// default halt instruction used by the CPU decoder and benches.
package cpu_dbg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RUN   = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_OUT   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_NONE    = 2'd0;
    localparam cause_t CAUSE_HALT    = 2'd1;
    localparam cause_t CAUSE_FORCE   = 2'd2;
    localparam cause_t CAUSE_TIMEOUT = 2'd3;

    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_dump_ctrl.sv
// Halt-detect and data-memory dump controller: stalls the core on a halt word,
// forced request or watchdog timeout, then streams memory out over valid/ready.
module mem_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned DATA_W                = 32,
    parameter int unsigned ADDR_W                = 10,
    parameter int unsigned DUMP_WORDS            = 1023,
    parameter int unsigned INSTR_W               = 32,
    parameter logic [INSTR_W-1:0] HALT_INSTR     = INSTR_W'(DEFAULT_HALT_INSTR),
    parameter int unsigned TIMEOUT               = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic              instr_valid,
    input  logic              force_dump,
    output logic              halt_req,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_last,
    output logic [1:0]        cause,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [31:0]         cyc_q, cyc_d;
    logic                halt_q, halt_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                last_q, last_d;
    cause_t              cause_q, cause_d;
    logic                done_q, done_d;

    logic hit_halt, hit_wd;

    assign hit_halt = instr_valid && (instruction == HALT_INSTR);
    // Fires on the RUN cycle that brings the count up to TIMEOUT.
    assign hit_wd   = (TIMEOUT != 0) && (cyc_q >= 32'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        halt_d  = halt_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cause_d = cause_q;
        done_d  = done_q;
        unique case (state_q)
            ST_RUN: begin
                cyc_d = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
                if (hit_halt || force_dump || hit_wd) begin
                    state_d = ST_ISSUE;
                    halt_d  = 1'b1;
                    cnt_d   = '0;
                    if (hit_halt)        cause_d = CAUSE_HALT;
                    else if (force_dump) cause_d = CAUSE_FORCE;
                    else                 cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                data_d  = mem_rd_data;
                addr_d  = cnt_q;
                last_d  = (cnt_q == LAST_ADDR);
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (dout_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            cyc_q   <= '0;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cause_q <= cause_d;
            done_q  <= done_d;
        end
    end

    assign halt_req    = halt_q;
    assign mem_rd_en   = (state_q == ST_ISSUE);
    assign mem_rd_addr = cnt_q;
    assign dout_valid  = valid_q;
    assign dout_data   = data_q;
    assign dout_addr   = addr_q;
    assign dout_last   = last_q;
    assign cause       = cause_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Directed bench for mem_dump_ctrl: halt, backpressure, priority, watchdog,
// mid-dump reset and single-word dumps against a small synchronous memory.
module tb_mem_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        rst_wd = 1'b1;
    logic        rst_one = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        instr_valid = 1'b0;
    logic        force_dump = 1'b0;
    logic        dout_ready = 1'b1;

    logic        halt_req, mem_rd_en, dout_valid, dout_last, done;
    logic [9:0]  mem_rd_addr, dout_addr;
    logic [31:0] mem_rd_data, dout_data;
    logic [1:0]  cause;

    logic        halt_wd, rd_en_wd, valid_wd, last_wd, done_wd;
    logic [9:0]  rd_addr_wd, addr_wd;
    logic [31:0] data_wd;
    logic [1:0]  cause_wd;

    logic        halt_one, rd_en_one, valid_one, last_one, done_one;
    logic [9:0]  rd_addr_one, addr_one;
    logic [31:0] rd_data_one, data_one;
    logic [1:0]  cause_one;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    mem_dump_ctrl #(.DUMP_WORDS(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .force_dump(force_dump), .halt_req(halt_req), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_data(dout_data), .dout_addr(dout_addr),
        .dout_last(dout_last), .cause(cause), .done(done)
    );

    mem_dump_ctrl #(.DUMP_WORDS(4), .TIMEOUT(20)) dut_wd (
        .clk(clk), .rst(rst_wd), .instruction(instruction), .instr_valid(instr_valid),
        .force_dump(force_dump), .halt_req(halt_wd), .mem_rd_en(rd_en_wd),
        .mem_rd_addr(rd_addr_wd), .mem_rd_data(32'h0), .dout_valid(valid_wd),
        .dout_ready(1'b1), .dout_data(data_wd), .dout_addr(addr_wd),
        .dout_last(last_wd), .cause(cause_wd), .done(done_wd)
    );

    mem_dump_ctrl #(.DUMP_WORDS(1)) dut_one (
        .clk(clk), .rst(rst_one), .instruction(instruction), .instr_valid(instr_valid),
        .force_dump(force_dump), .halt_req(halt_one), .mem_rd_en(rd_en_one),
        .mem_rd_addr(rd_addr_one), .mem_rd_data(rd_data_one), .dout_valid(valid_one),
        .dout_ready(dout_ready), .dout_data(data_one), .dout_addr(addr_one),
        .dout_last(last_one), .cause(cause_one), .done(done_one)
    );

    // Memory word at address a holds (a+1)*0x11, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 32'(mem_rd_addr + 10'd1) * 32'h11;
        if (rd_en_one) rd_data_one <= 32'(rd_addr_one + 10'd1) * 32'h11;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Called in cycle T+1 after a trigger sampled at edge T; returns the
    // cycle offset at which done is first seen.
    task automatic collect_dump(input int stall_len, output int done_k);
        int k = 1;
        int idx = 0;
        int stall = 0;
        done_k = -1;
        dout_ready = 1'b1;
        checks++;
        if ({halt_req, mem_rd_en, mem_rd_addr} !== {1'b1, 1'b1, 10'd0}) begin
            failures++;
            $display("FAIL first_issue: halt/rd_en/addr=%b/%b/%0d required 1/1/0",
                     halt_req, mem_rd_en, mem_rd_addr);
        end
        while (k < 100 && done_k < 0) begin
            if (done) begin
                done_k = k;
            end else begin
                if (dout_valid) begin
                    if (idx == 1 && stall < stall_len) begin
                        dout_ready = 1'b0;
                        stall++;
                        checks++;
                        if (dout_data !== 32'h22 || dout_addr !== 10'd1) begin
                            failures++;
                            $display("FAIL stall_stable: data=%h addr=%0d required 22/1",
                                     dout_data, dout_addr);
                        end
                    end else begin
                        dout_ready = 1'b1;
                        checks++;
                        if (dout_data !== exp_words[idx] || dout_addr !== 10'(idx) ||
                            dout_last !== (idx == 3)) begin
                            failures++;
                            $display("FAIL word%0d: data=%h addr=%0d last=%b required %h/%0d/%b",
                                     idx, dout_data, dout_addr, dout_last, exp_words[idx],
                                     idx, (idx == 3));
                        end
                        if (idx == 0) begin
                            checks++;
                            if (k != 3) begin
                                failures++;
                                $display("FAIL first_valid_cycle: got T+%0d required T+3", k);
                            end
                        end
                        idx++;
                    end
                end else begin
                    dout_ready = 1'b1;
                end
                if (idx > 4) k = 100;
                tick();
                k++;
            end
        end
        dout_ready = 1'b1;
        checks++;
        if (done_k < 0 || idx != 4 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL dump_complete: done_k=%0d words=%0d valid=%b required words=4 valid=0",
                     done_k, idx, dout_valid);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({halt_req, mem_rd_en, mem_rd_addr, dout_valid, dout_data, dout_addr, dout_last,
             cause, done} !== '0) begin
            failures++;
            $display("FAIL reset_values: halt=%b rd=%b valid=%b data=%h cause=%0d done=%b",
                     halt_req, mem_rd_en, dout_valid, dout_data, cause, done);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_halt;
        int dk;
        do_reset();
        tick();
        instruction = 32'hFFFF_FFFF;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instruction = 32'h0;
        collect_dump(0, dk);
        checks++;
        if (dk != 13 || cause !== 2'd1) begin
            failures++;
            $display("FAIL halt_done: done at T+%0d cause=%0d required T+13 cause=1", dk, cause);
        end
    endtask

    task automatic test_back_to_back;
        int dk;
        do_reset();
        instruction = 32'hFFFF_FFFF;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instruction = 32'h0;
        collect_dump(5, dk);
        checks++;
        if (dk != 18) begin
            failures++;
            $display("FAIL backpressure_done: done at T+%0d required T+18", dk);
        end
    endtask

    task automatic test_priority;
        int dk;
        do_reset();
        instruction = 32'hFFFF_FFFF;
        instr_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (halt_req !== 1'b0 || mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL bubble_ignored: halt=%b rd_en=%b required 0/0", halt_req, mem_rd_en);
        end
        instr_valid = 1'b1;
        force_dump = 1'b1;
        tick();
        instr_valid = 1'b0;
        force_dump = 1'b0;
        instruction = 32'h0;
        collect_dump(0, dk);
        checks++;
        if (cause !== 2'd1 || dk != 13) begin
            failures++;
            $display("FAIL halt_over_force: cause=%0d done_k=%0d required 1/13", cause, dk);
        end
        force_dump = 1'b1;
        tick();
        force_dump = 1'b0;
        repeat (2) tick();
        checks++;
        if ({done, halt_req, cause, dout_valid, mem_rd_en} !== {1'b1, 1'b1, 2'd1, 1'b0, 1'b0})
        begin
            failures++;
            $display("FAIL done_frozen: done=%b halt=%b cause=%0d valid=%b rd_en=%b",
                     done, halt_req, cause, dout_valid, mem_rd_en);
        end
    endtask

    task automatic test_watchdog;
        instruction = 32'h0;
        instr_valid = 1'b0;
        rst_wd = 1'b0;
        repeat (19) tick();
        checks++;
        if (halt_wd !== 1'b0) begin
            failures++;
            $display("FAIL wd_early: halt=%b after 19 RUN cycles required 0", halt_wd);
        end
        tick();
        checks++;
        if ({halt_wd, rd_en_wd, rd_addr_wd, cause_wd} !== {1'b1, 1'b1, 10'd0, 2'd3}) begin
            failures++;
            $display("FAIL wd_trigger: halt=%b rd_en=%b cause=%0d required 1/1/3",
                     halt_wd, rd_en_wd, cause_wd);
        end
    endtask

    task automatic test_no_timeout;
        do_reset();
        instruction = 32'h0;
        instr_valid = 1'b1;
        repeat (10000) tick();
        instr_valid = 1'b0;
        checks++;
        if (halt_req !== 1'b0 || cause !== 2'd0) begin
            failures++;
            $display("FAIL wd_disabled: halt=%b cause=%0d required 0/0", halt_req, cause);
        end
    endtask

    task automatic test_reset_mid_dump;
        int dk;
        int n = 0;
        do_reset();
        force_dump = 1'b1;
        tick();
        force_dump = 1'b0;
        while (n < 30 && !(dout_valid && dout_addr == 10'd2)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 30) begin
            failures++;
            $display("FAIL reach_word2: word 2 never presented, got %0d cycles required < 30", n);
        end
        dout_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({halt_req, mem_rd_en, mem_rd_addr, dout_valid, dout_data, dout_addr, dout_last,
             cause, done} !== '0) begin
            failures++;
            $display("FAIL async_reset: halt=%b valid=%b data=%h addr=%0d cause=%0d required 0",
                     halt_req, dout_valid, dout_data, dout_addr, cause);
        end
        dout_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        force_dump = 1'b1;
        tick();
        force_dump = 1'b0;
        collect_dump(0, dk);
        checks++;
        if (cause !== 2'd2 || dk != 13) begin
            failures++;
            $display("FAIL restart_force: cause=%0d done_k=%0d required 2/13", cause, dk);
        end
    endtask

    task automatic test_single_word;
        rst_one = 1'b0;
        tick();
        force_dump = 1'b1;
        tick();
        force_dump = 1'b0;
        dout_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if ({valid_one, last_one, data_one, addr_one} !== {1'b1, 1'b1, 32'h11, 10'd0}) begin
            failures++;
            $display("FAIL single_word: valid=%b last=%b data=%h addr=%0d required 1/1/11/0",
                     valid_one, last_one, data_one, addr_one);
        end
        tick();
        checks++;
        if ({done_one, valid_one, cause_one} !== {1'b1, 1'b0, 2'd2}) begin
            failures++;
            $display("FAIL single_done: done=%b valid=%b cause=%0d required 1/0/2",
                     done_one, valid_one, cause_one);
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_back_to_back();
        test_priority();
        test_watchdog();
        test_reset_mid_dump();
        test_single_word();
        test_no_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
